// File: rtl/core_quant_pack_if.sv
// Bundle of the configuration, accumulator-side and packed-output signals of core_quant_pack.
// master drives config/data/ready; slave is the quantizer/packer itself.
interface core_quant_pack_if #(
  parameter int IDATA_BIT = 32,
  parameter int ODATA_BIT = 8,
  parameter int SCALE_BIT = 16,
  parameter int SHIFT_BIT = 6,
  parameter int PACK_NUM  = 4
);
  logic        [SCALE_BIT-1:0]          cfg_quant_scale;
  logic        [SHIFT_BIT-1:0]          cfg_quant_shift;
  logic signed [ODATA_BIT-1:0]          cfg_quant_zp;
  logic signed [IDATA_BIT-1:0]          idata;
  logic                                 idata_valid;
  logic                                 flush;
  logic        [ODATA_BIT*PACK_NUM-1:0] odata;
  logic                                 odata_valid;
  logic                                 odata_ready;
  logic                                 err_overflow;

  modport master (
    output cfg_quant_scale, cfg_quant_shift, cfg_quant_zp,
    output idata, idata_valid, flush, odata_ready,
    input  odata, odata_valid, err_overflow
  );

  modport slave (
    input  cfg_quant_scale, cfg_quant_shift, cfg_quant_zp,
    input  idata, idata_valid, flush, odata_ready,
    output odata, odata_valid, err_overflow
  );
endinterface

// File: rtl/core_quant_pack.sv
// Requantizes signed accumulator results (scale, round-half-up shift, zero-point, saturate),
// packs PACK_NUM lanes per word and buffers words in a 2-entry FIFO with a sticky drop flag.
module core_quant_pack #(
  parameter int IDATA_BIT = 32,
  parameter int ODATA_BIT = 8,
  parameter int SCALE_BIT = 16,
  parameter int SHIFT_BIT = 6,
  parameter int PACK_NUM  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  core_quant_pack_if.slave bus
);

  localparam int PROD_W = IDATA_BIT + SCALE_BIT + 1;
  localparam int RND_W  = PROD_W + 1;
  localparam int SUM_W  = RND_W + 1;
  localparam int WORD_W = ODATA_BIT * PACK_NUM;
  localparam int LANE_W = $clog2(PACK_NUM);

  localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'((2 ** (ODATA_BIT - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-(2 ** (ODATA_BIT - 1)));

  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic        [SHIFT_BIT-1:0] sh
  );
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] bias;
    ext = RND_W'(p);
    if (sh == '0) return ext;
    bias = RND_W'(1) <<< (sh - SHIFT_BIT'(1));
    return (ext + bias) >>> sh;
  endfunction

  function automatic logic signed [ODATA_BIT-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > Q_MAX) return Q_MAX[ODATA_BIT-1:0];
    if (s < Q_MIN) return Q_MIN[ODATA_BIT-1:0];
    return s[ODATA_BIT-1:0];
  endfunction

  // ---- stage 1: multiply by unsigned scale ----
  logic signed [PROD_W-1:0] prod_p1_d, prod_p1_q;
  logic                     vld_p1_q, flush_p1_q;

  always_comb begin
    prod_p1_d = PROD_W'(bus.idata) * PROD_W'($signed({1'b0, bus.cfg_quant_scale}));
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q   <= 1'b0;
      flush_p1_q <= 1'b0;
    end else begin
      vld_p1_q   <= bus.idata_valid;
      flush_p1_q <= bus.flush;
    end
  end

  // ---- stage 2: round, shift, zero-point, saturate ----
  logic signed [RND_W-1:0]     r_p2;
  logic signed [SUM_W-1:0]     s_p2;
  logic signed [ODATA_BIT-1:0] q_p2_d, q_p2_q;
  logic                        vld_p2_q, flush_p2_q;

  always_comb begin
    r_p2   = round_shift(prod_p1_q, bus.cfg_quant_shift);
    s_p2   = SUM_W'(r_p2) + SUM_W'(bus.cfg_quant_zp);
    q_p2_d = saturate(s_p2);
  end

  always_ff @(posedge clk) begin
    q_p2_q <= q_p2_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2_q   <= 1'b0;
      flush_p2_q <= 1'b0;
    end else begin
      vld_p2_q   <= vld_p1_q;
      flush_p2_q <= flush_p1_q;
    end
  end

  // ---- stage 3: lane packing ----
  logic [LANE_W-1:0] lane_cnt_d, lane_cnt_q;
  logic [WORD_W-1:0] pack_d, pack_q, word_w;
  logic              push;

  always_comb begin
    word_w = pack_q;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (vld_p2_q && lane_cnt_q == LANE_W'(i)) word_w[i*ODATA_BIT +: ODATA_BIT] = q_p2_q;
    end
    push = (vld_p2_q && lane_cnt_q == LANE_W'(PACK_NUM - 1)) ||
           (flush_p2_q && (lane_cnt_q != '0 || vld_p2_q));
    lane_cnt_d = lane_cnt_q;
    pack_d     = pack_q;
    // A completed word always restarts the packer, whether or not the FIFO took it.
    if (push) begin
      lane_cnt_d = '0;
      pack_d     = '0;
    end else if (vld_p2_q) begin
      lane_cnt_d = lane_cnt_q + LANE_W'(1);
      pack_d     = word_w;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
    end
  end

  // ---- output FIFO (2 entries) ----
  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [1:0]        cnt_d, cnt_q;
  logic              pop, accept, err_d, err_q;

  always_comb begin
    pop    = (cnt_q != 2'd0) && bus.odata_ready;
    accept = push && ((cnt_q != 2'd2) || pop);
    wr_ptr_d = accept ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (push & ~accept);
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= word_w;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Head is gated by occupancy so odata reads 0 out of reset without clearing the storage.
  assign bus.odata        = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign bus.odata_valid  = (cnt_q != 2'd0);
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_core_quant_pack.sv
// Scoreboard bench for core_quant_pack: directed cases plus randomized bursts against a
// 64-bit integer model of the requantize/pack rules.
module tb_core_quant_pack;
  localparam int IDATA_BIT = 32;
  localparam int ODATA_BIT = 8;
  localparam int SCALE_BIT = 16;
  localparam int SHIFT_BIT = 6;
  localparam int PACK_NUM  = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  core_quant_pack_if #(
    .IDATA_BIT(IDATA_BIT), .ODATA_BIT(ODATA_BIT), .SCALE_BIT(SCALE_BIT),
    .SHIFT_BIT(SHIFT_BIT), .PACK_NUM(PACK_NUM)
  ) bus ();

  core_quant_pack #(
    .IDATA_BIT(IDATA_BIT), .ODATA_BIT(ODATA_BIT), .SCALE_BIT(SCALE_BIT),
    .SHIFT_BIT(SHIFT_BIT), .PACK_NUM(PACK_NUM)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          rand_ready = 0;
  int          m_lanes = 0;
  logic [31:0] m_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output word is compared with the head of the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn && bus.odata_valid && bus.odata_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %08h expected no word at %0t", bus.odata, $time);
      end else begin
        e = exp_q.pop_front();
        check("word", bus.odata, e);
      end
    end
  end

  function automatic logic [7:0] mquant(input int x);
    longint p, sc, r;
    int     sh;
    sc = bus.cfg_quant_scale;
    sh = int'(bus.cfg_quant_shift);
    p  = longint'(x) * sc;
    if (sh == 0) r = p;
    else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    r = r + longint'(bus.cfg_quant_zp);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic model_in(input bit v, input int x, input bit f);
    if (v) begin
      m_word[m_lanes*8 +: 8] = mquant(x);
      m_lanes++;
    end
    if (m_lanes == PACK_NUM || (f && m_lanes > 0)) begin
      exp_q.push_back(m_word);
      m_word  = '0;
      m_lanes = 0;
    end
  endtask

  task automatic drive(input bit v, input int x, input bit f);
    @(posedge clk);
    #1;
    bus.idata_valid = v;
    bus.idata       = x;
    bus.flush       = f;
    if (rand_ready) bus.odata_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      drive(0, 0, 0);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  // Holds back any input that would complete a word while two words are outstanding.
  task automatic stim(input bit v, input int x, input bit f);
    bit completes;
    int k = 0;
    completes = (v && m_lanes == PACK_NUM - 1) || (f && (m_lanes > 0 || v));
    while (completes && exp_q.size() >= 2 && k < 300) begin
      drive(0, 0, 0);
      k++;
    end
    if (completes && exp_q.size() >= 2) begin
      n_checks++;
      n_fail++;
      $display("FAIL throttle_timeout: pending %0d required below 2", exp_q.size());
    end
    drive(v, x, f);
    model_in(v, x, f);
  endtask

  task automatic set_cfg(input int sc, input int sh, input int zp);
    bus.cfg_quant_scale = 16'(sc);
    bus.cfg_quant_shift = 6'(sh);
    bus.cfg_quant_zp    = 8'(zp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.idata_valid = 1'b0;
    bus.idata       = '0;
    bus.flush       = 1'b0;
    bus.odata_ready = 1'b1;
    set_cfg(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_odata", bus.odata, 32'h0);
    check("reset_valid", 32'(bus.odata_valid), 32'h0);
    check("reset_err", 32'(bus.err_overflow), 32'h0);
    rstn = 1'b1;
    idle(2);

    // Basic packing and latency
    exp_q.push_back(32'hFF030201);
    drive(1, 1, 0);
    drive(1, 2, 0);
    drive(1, 3, 0);
    drive(1, -1, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0);
      check($sformatf("latency_valid_%0d", k), 32'(bus.odata_valid), (k == 3) ? 32'h1 : 32'h0);
    end
    wait_drain("basic_drain");

    // Rounding
    set_cfg(3, 2, 0);
    exp_q.push_back(32'h0000FC04);
    drive(1, 5, 0);
    drive(1, -5, 0);
    drive(0, 0, 1);
    wait_drain("round_drain");
    set_cfg(1, 2, 0);
    exp_q.push_back(32'h00000002);
    drive(1, 6, 1);
    wait_drain("halfup_drain");
    set_cfg(3, 2, 10);
    exp_q.push_back(32'h0000060E);
    drive(1, 5, 0);
    drive(1, -5, 1);
    wait_drain("zp_drain");

    // Saturation
    set_cfg(1, 0, 0);
    exp_q.push_back(32'h0000807F);
    drive(1, 1000, 0);
    drive(1, -1000, 1);
    wait_drain("sat_drain");
    set_cfg(1, 0, 20);
    exp_q.push_back(32'h0000007F);
    drive(1, 120, 1);
    wait_drain("sat_zp_drain");

    // Partial flush, then an empty flush that must emit nothing
    set_cfg(1, 0, 0);
    exp_q.push_back(32'h00000807);
    drive(1, 7, 0);
    drive(1, 8, 0);
    drive(0, 0, 1);
    wait_drain("partial_drain");
    drive(0, 0, 1);
    idle(6);
    check("empty_flush_valid", 32'(bus.odata_valid), 32'h0);

    // Backpressure and overflow
    bus.odata_ready = 1'b0;
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    for (int i = 1; i <= 12; i++) drive(1, i, 0);
    idle(4);
    check("ovf_err", 32'(bus.err_overflow), 32'h1);
    check("ovf_valid", 32'(bus.odata_valid), 32'h1);
    check("ovf_head", bus.odata, 32'h04030201);
    idle(2);
    check("ovf_head_stable", bus.odata, 32'h04030201);
    bus.odata_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_empty", 32'(bus.odata_valid), 32'h0);
    check("ovf_sticky", 32'(bus.err_overflow), 32'h1);

    // Mid-stream reset
    drive(1, 50, 0);
    drive(1, 60, 0);
    @(posedge clk);
    #1;
    bus.idata_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_odata", bus.odata, 32'h0);
    check("rst_valid", 32'(bus.odata_valid), 32'h0);
    check("rst_err", 32'(bus.err_overflow), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.push_back(32'h44332211);
    drive(1, 17, 0);
    drive(1, 34, 0);
    drive(1, 51, 0);
    drive(1, 68, 0);
    wait_drain("post_rst_drain");

    // Full FIFO with pop in the push cycle
    bus.odata_ready = 1'b0;
    exp_q.push_back(32'h68676665);
    exp_q.push_back(32'h6C6B6A69);
    exp_q.push_back(32'h706F6E6D);
    for (int i = 101; i <= 112; i++) drive(1, i, 0);
    drive(0, 0, 0);
    @(posedge clk);
    #1;
    bus.odata_ready = 1'b1;
    wait_drain("fullpop_drain");
    check("fullpop_no_err", 32'(bus.err_overflow), 32'h0);

    // Randomized bursts with random backpressure
    m_lanes = 0;
    m_word  = '0;
    for (int b = 0; b < 10; b++) begin
      int sh;
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 47)) : int'($urandom_range(0, 16));
      set_cfg(int'($urandom_range(0, 65535)), sh, int'($urandom_range(0, 255)));
      rand_ready = 1;
      for (int c = 0; c < 60; c++) begin
        bit v, f;
        int x;
        v = ($urandom_range(0, 3) != 0);
        f = ($urandom_range(0, 9) == 0);
        x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
        stim(v, x, f);
      end
      stim(0, 0, 1);
      rand_ready = 0;
      bus.odata_ready = 1'b1;
      wait_drain("rand_drain");
    end
    check("rand_no_err", 32'(bus.err_overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
